// File: rtl/intc_pkg.sv
// intc_pkg: shared definitions for the priority interrupt controller.
//   LVL_NONE  - level code meaning "no request"
//   OINT_IDLE - active-low OINT_n value presented when nothing is requested
//   state_e   - handshake FSM states
//   prio7     - highest set bit of a 7-bit vector as a 3-bit level (0 = none)
package intc_pkg;

  localparam int unsigned N_LVL     = 7;
  localparam logic [2:0]  LVL_NONE  = 3'd0;
  localparam logic [2:0]  OINT_IDLE = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACKW = 2'd2
  } state_e;

  // Bit i maps to level i+1; the loop runs upwards so the highest set bit wins.
  function automatic logic [2:0] prio7(input logic [6:0] vec);
    logic [2:0] lvl;
    lvl = LVL_NONE;
    for (int i = 0; i < 7; i++) begin
      if (vec[i]) lvl = 3'(i + 1);
    end
    return lvl;
  endfunction

endpackage

// File: rtl/intc_if.sv
// intc_if: source, software and processor-side signals of the interrupt controller.
//   irq, mask_we, mask_wdata, eoi, IACK_n   - driven into the controller
//   OINT_n, ack_vld, ack_level              - processor-side request/acknowledge outputs
//   pend, isr, mask                         - status readback
// Modport slave is the controller view; master is the driver (system/testbench) view.
interface intc_if;
  import intc_pkg::*;

  logic [N_LVL-1:0] irq;
  logic             mask_we;
  logic [N_LVL-1:0] mask_wdata;
  logic             eoi;
  logic             IACK_n;
  logic [2:0]       OINT_n;
  logic             ack_vld;
  logic [2:0]       ack_level;
  logic [N_LVL-1:0] pend;
  logic [N_LVL-1:0] isr;
  logic [N_LVL-1:0] mask;

  modport master (
    output irq, mask_we, mask_wdata, eoi, IACK_n,
    input  OINT_n, ack_vld, ack_level, pend, isr, mask
  );

  modport slave (
    input  irq, mask_we, mask_wdata, eoi, IACK_n,
    output OINT_n, ack_vld, ack_level, pend, isr, mask
  );

endinterface

// File: rtl/intc_prio.sv
// intc_prio: combinational 7-to-3 priority encoder.
//   vec - request vector, bit i = level i+1
//   lvl - highest level present in vec, 0 when vec is empty
module intc_prio
  import intc_pkg::*;
(
  input  logic [6:0] vec,
  output logic [2:0] lvl
);

  assign lvl = prio7(vec);

endmodule

// File: rtl/intc.sv
// intc: seven-source priority interrupt controller in front of the processor.
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - intc_if.slave: irq/mask/eoi/IACK_n in; OINT_n, ack_vld/ack_level, pend/isr/mask out
// Rising irq edges latch into pend; the highest unmasked pending level above the
// highest in-service level is presented on OINT_n (active low). An IACK_n low
// sample while presenting retires the request into isr; eoi retires the top isr bit.
module intc
  import intc_pkg::*;
#(
  parameter int unsigned N_SRC = 7
) (
  input logic    clk,
  input logic    rst,
  intc_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_REQ  = 2'(REQ);
  localparam logic [1:0] ST_ACKW = 2'(ACKW);

  logic [1:0]       state_q, state_d;
  logic [2:0]       cur_q, cur_d;
  logic [2:0]       oint_q, oint_d;
  logic             ack_vld_q, ack_vld_d;
  logic [2:0]       ack_lvl_q, ack_lvl_d;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] isr_q, isr_d;
  logic [N_SRC-1:0] mask_q, mask_d;

  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] isr_set;
  logic [N_SRC-1:0] cur_oh;
  logic [N_SRC-1:0] isr_top_oh;
  logic [2:0]       cand;
  logic [2:0]       isr_top;

  assign elig = pend_q & ~mask_q;

  intc_prio u_prio_elig (
    .vec (elig),
    .lvl (cand)
  );

  intc_prio u_prio_isr (
    .vec (isr_q),
    .lvl (isr_top)
  );

  // Level L maps to bit L-1; level 0 shifts the bit out and yields zero.
  assign cur_oh     = N_SRC'(1) << (cur_q - 3'd1);
  assign isr_top_oh = N_SRC'(1) << (isr_top - 3'd1);

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    clr       = '0;
    isr_set   = '0;
    ack_vld_d = 1'b0;
    ack_lvl_d = ack_lvl_q;

    case (state_q)
      ST_IDLE: begin
        if (cand > isr_top) begin
          state_d = ST_REQ;
          cur_d   = cand;
        end
      end
      ST_REQ: begin
        // The processor acknowledges what it has seen presented, so accepting
        // the acknowledge takes precedence over withdraw and upgrade.
        if (!bus.IACK_n) begin
          clr       = cur_oh;
          isr_set   = cur_oh;
          ack_vld_d = 1'b1;
          ack_lvl_d = cur_q;
          state_d   = ST_ACKW;
        end else if (((mask_q & cur_oh) != '0) || (cur_q <= isr_top)) begin
          state_d = ST_IDLE;
        end else if (cand > cur_q) begin
          cur_d = cand;
        end
      end
      ST_ACKW: begin
        if (bus.IACK_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    oint_d = (state_d == ST_REQ) ? ~cur_d : OINT_IDLE;

    // EOI works on the pre-acknowledge isr; the new bit is always above it.
    isr_d = isr_q;
    if (bus.eoi && (isr_top != LVL_NONE)) isr_d = isr_d & ~isr_top_oh;
    isr_d = isr_d | isr_set;

    // A fresh edge on the bit being acknowledged survives the clear.
    pend_d = (pend_q & ~clr) | (bus.irq & ~irq_q);

    mask_d = bus.mask_we ? bus.mask_wdata : mask_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_q     <= LVL_NONE;
      oint_q    <= OINT_IDLE;
      ack_vld_q <= 1'b0;
      ack_lvl_q <= LVL_NONE;
      irq_q     <= '0;
      pend_q    <= '0;
      isr_q     <= '0;
      mask_q    <= '1;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      oint_q    <= oint_d;
      ack_vld_q <= ack_vld_d;
      ack_lvl_q <= ack_lvl_d;
      irq_q     <= bus.irq;
      pend_q    <= pend_d;
      isr_q     <= isr_d;
      mask_q    <= mask_d;
    end
  end

  assign bus.OINT_n    = oint_q;
  assign bus.ack_vld   = ack_vld_q;
  assign bus.ack_level = ack_lvl_q;
  assign bus.pend      = pend_q;
  assign bus.isr       = isr_q;
  assign bus.mask      = mask_q;

endmodule

// File: tb/tb_intc.sv
// tb_intc: directed scenarios with literal expectations, then randomized traffic,
// all outputs checked every cycle against a level-based behavioural model.
module tb_intc;

  logic clk;
  logic rst;
  intc_if bus ();

  intc #(.N_SRC(7)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Highest requesting level in a bit set (bit i = level i+1), 0 if empty.
  function automatic int hi(input logic [6:0] v);
    for (int l = 7; l >= 1; l--) begin
      if (v[l-1]) return l;
    end
    return 0;
  endfunction

  // Behavioural model: phase 0 = nothing shown, 1 = presenting m_cur, 2 = waiting release.
  logic [6:0] m_pend, m_isr, m_mask, m_prev;
  int         m_phase, m_cur, m_ack_lvl;
  bit         m_ack;
  bit         model_valid = 0;
  int         t_top, t_cand;
  logic [6:0] t_clr, t_isr;

  always @(posedge clk) begin
    if (rst) begin
      m_pend = '0; m_isr = '0; m_mask = 7'h7F; m_prev = '0;
      m_phase = 0; m_cur = 0; m_ack = 0; m_ack_lvl = 0;
      model_valid = 1;
    end else begin
      t_top  = hi(m_isr);
      t_cand = hi(m_pend & ~m_mask);
      t_clr  = '0;
      t_isr  = m_isr;
      m_ack  = 0;
      if (bus.eoi && t_top > 0) t_isr[t_top-1] = 1'b0;
      if (m_phase == 0) begin
        if (t_cand > t_top) begin
          m_phase = 1;
          m_cur   = t_cand;
        end
      end else if (m_phase == 1) begin
        if (!bus.IACK_n) begin
          m_ack = 1;
          m_ack_lvl = m_cur;
          t_clr[m_cur-1] = 1'b1;
          t_isr[m_cur-1] = 1'b1;
          m_phase = 2;
        end else if (m_mask[m_cur-1] || m_cur <= t_top) begin
          m_phase = 0;
        end else if (t_cand > m_cur) begin
          m_cur = t_cand;
        end
      end else begin
        if (bus.IACK_n) m_phase = 0;
      end
      m_pend = (m_pend & ~t_clr) | (bus.irq & ~m_prev);
      m_prev = bus.irq;
      m_isr  = t_isr;
      if (bus.mask_we) m_mask = bus.mask_wdata;
    end
  end

  logic [2:0] exp_oint;
  always @(negedge clk) begin
    if (model_valid) begin
      exp_oint = (m_phase == 1) ? ~3'(m_cur) : 3'b111;
      chk("model OINT_n", 7'(bus.OINT_n), 7'(exp_oint));
      chk("model ack_vld", 7'(bus.ack_vld), 7'(m_ack));
      if (m_ack) chk("model ack_level", 7'(bus.ack_level), 7'(m_ack_lvl));
      chk("model pend", bus.pend, m_pend);
      chk("model isr", bus.isr, m_isr);
      chk("model mask", bus.mask, m_mask);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.irq = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0; bus.eoi = 1'b0; bus.IACK_n = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset OINT_n", 7'(bus.OINT_n), 7'h07);
    chk("reset pend", bus.pend, 7'h00);
    chk("reset isr", bus.isr, 7'h00);
    chk("reset mask", bus.mask, 7'h7F);
    chk("reset ack_vld", 7'(bus.ack_vld), 7'h0);

    // Unmask and a single request on level 3
    bus.mask_we = 1'b1; bus.mask_wdata = 7'h00; tick(); bus.mask_we = 1'b0;
    bus.irq = 7'h04; tick();
    chk("t1 pend set", bus.pend, 7'h04);
    chk("t1 OINT_n not yet", 7'(bus.OINT_n), 7'h07);
    bus.irq = 7'h00; tick();
    chk("t1 OINT_n lvl3", 7'(bus.OINT_n), 7'(3'b100));
    bus.IACK_n = 1'b0; tick();
    chk("t1 ack_vld", 7'(bus.ack_vld), 7'h1);
    chk("t1 ack_level", 7'(bus.ack_level), 7'd3);
    chk("t1 pend clr", bus.pend, 7'h00);
    chk("t1 isr", bus.isr, 7'h04);
    chk("t1 OINT_n idle", 7'(bus.OINT_n), 7'h07);
    bus.IACK_n = 1'b1; tick();
    chk("t1 ack_vld drop", 7'(bus.ack_vld), 7'h0);
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    chk("t1 eoi", bus.isr, 7'h00);

    // Priority upgrade 2 -> 6
    bus.irq = 7'h02; tick();
    bus.irq = 7'h20; tick();
    chk("t2 OINT_n lvl2", 7'(bus.OINT_n), 7'(3'b101));
    bus.irq = 7'h00; tick();
    chk("t2 OINT_n lvl6", 7'(bus.OINT_n), 7'(3'b001));
    bus.IACK_n = 1'b0; tick();
    chk("t2 ack_level", 7'(bus.ack_level), 7'd6);
    chk("t2 pend remains", bus.pend, 7'h02);
    bus.IACK_n = 1'b1; tick();
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    tick();
    chk("t2 OINT_n lvl2 again", 7'(bus.OINT_n), 7'(3'b101));
    bus.IACK_n = 1'b0; tick(); bus.IACK_n = 1'b1; tick();
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    chk("t2 isr clean", bus.isr, 7'h00);

    // Nesting with level 5 in service
    bus.irq = 7'h10; tick(); bus.irq = 7'h00; tick();
    bus.IACK_n = 1'b0; tick(); bus.IACK_n = 1'b1; tick();
    chk("t3 isr lvl5", bus.isr, 7'h10);
    bus.irq = 7'h08; tick(); bus.irq = 7'h00; tick();
    chk("t3 lvl4 blocked", 7'(bus.OINT_n), 7'h07);
    bus.irq = 7'h40; tick(); bus.irq = 7'h00; tick();
    chk("t3 lvl7 nests", 7'(bus.OINT_n), 7'(3'b000));
    bus.IACK_n = 1'b0; tick(); bus.IACK_n = 1'b1;
    chk("t3 isr nested", bus.isr, 7'h50);
    tick();
    bus.eoi = 1'b1; tick();
    chk("t3 eoi1", bus.isr, 7'h10);
    tick(); bus.eoi = 1'b0;
    chk("t3 eoi2", bus.isr, 7'h00);
    tick();
    chk("t3 lvl4 presented", 7'(bus.OINT_n), 7'(3'b011));
    bus.IACK_n = 1'b0; tick(); bus.IACK_n = 1'b1; tick();
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;

    // Mask withdraw and re-present
    bus.irq = 7'h04; tick(); bus.irq = 7'h00; tick();
    chk("t4 lvl3", 7'(bus.OINT_n), 7'(3'b100));
    bus.mask_we = 1'b1; bus.mask_wdata = 7'h04; tick(); bus.mask_we = 1'b0;
    chk("t4 mask", bus.mask, 7'h04);
    tick();
    chk("t4 withdrawn", 7'(bus.OINT_n), 7'h07);
    chk("t4 pend kept", bus.pend, 7'h04);
    bus.mask_we = 1'b1; bus.mask_wdata = 7'h00; tick(); bus.mask_we = 1'b0;
    tick();
    chk("t4 re-presented", 7'(bus.OINT_n), 7'(3'b100));
    bus.IACK_n = 1'b0; tick(); bus.IACK_n = 1'b1; tick();

    // Spurious acknowledge, set-wins-clear, eoi with acknowledge
    bus.IACK_n = 1'b0; tick(); bus.IACK_n = 1'b1;
    chk("t5 spurious ack", 7'(bus.ack_vld), 7'h0);
    chk("t5 isr unchanged", bus.isr, 7'h04);
    tick();
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    bus.irq = 7'h01; tick(); bus.irq = 7'h00; tick();
    chk("t5 lvl1", 7'(bus.OINT_n), 7'(3'b110));
    bus.IACK_n = 1'b0; bus.irq = 7'h01; tick();
    chk("t5 ack lvl1", 7'(bus.ack_level), 7'd1);
    chk("t5 set wins", bus.pend, 7'h01);
    bus.IACK_n = 1'b1; bus.irq = 7'h00; tick();
    bus.irq = 7'h10; tick(); bus.irq = 7'h00; tick();
    bus.IACK_n = 1'b0; bus.eoi = 1'b1; tick();
    chk("t5 eoi+ack isr", bus.isr, 7'h10);
    chk("t5 eoi+ack lvl", 7'(bus.ack_level), 7'd5);
    bus.IACK_n = 1'b1; bus.eoi = 1'b0; tick();

    // Reset while waiting for IACK_n release
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    tick();
    bus.IACK_n = 1'b0; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6 OINT_n", 7'(bus.OINT_n), 7'h07);
    chk("t6 pend", bus.pend, 7'h00);
    chk("t6 isr", bus.isr, 7'h00);
    chk("t6 mask", bus.mask, 7'h7F);
    chk("t6 ack_vld", 7'(bus.ack_vld), 7'h0);
    tick();
    chk("t6 ack_vld later", 7'(bus.ack_vld), 7'h0);
    bus.IACK_n = 1'b1;

    // Randomized traffic checked by the model
    bus.mask_we = 1'b1; bus.mask_wdata = 7'h00; tick(); bus.mask_we = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 7; b++) begin
        if ($urandom_range(0, 7) == 0) bus.irq[b] = ~bus.irq[b];
      end
      bus.mask_we    = ($urandom_range(0, 31) == 0);
      bus.mask_wdata = 7'($urandom & $urandom);
      bus.eoi        = ($urandom_range(0, 11) == 0);
      if (bus.OINT_n != 3'b111) begin
        bus.IACK_n = ($urandom_range(0, 2) != 0);
      end else if (!bus.IACK_n) begin
        bus.IACK_n = ($urandom_range(0, 1) == 0);
      end else begin
        bus.IACK_n = ($urandom_range(0, 19) != 0);
      end
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
